ysyx_23060077_lsu_align: RTL
============================

// Module: ysyx_23060077_lsu_align
// PURPOSE
// - Parametrised load/store unit between EX and the AXI-lite style memory arbiter.
// - Explicit request/response FSM with lane alignment (addr offset shift, byte strobes).
// - Adds sign/zero extension after lane shift, a bus-timeout watchdog and a response handshake to WB.
// PARAMETERS
// - DATA_WIDTH      32  GPR/bus data width; must be 32 or 64; OFS_W = log2(DATA_WIDTH/8).
// - ADDR_WIDTH      32  Bus address width.
// - TIMEOUT_CYCLES  256 Max cycles in RD/WR before an error response; 0 disables the watchdog.
// PORTS
// - clock        in   1           System clock.
// - reset        in   1           Synchronous, active-high reset.
// - req_valid    in   1           EX presents a memory op.
// - req_ready    out  1           High only in IDLE; accept = req_valid & req_ready.
// - req_store    in   1           1 = store, 0 = load.
// - req_funct3   in   3           RV funct3: [1:0] size (0=B,1=H,2=W,3=D if 64-bit), [2] unsigned.
// - req_base     in   DATA_WIDTH  rs1 value.
// - req_imm      in   DATA_WIDTH  Sign-extended offset; EA = req_base + req_imm (modulo 2^DATA_WIDTH).
// - req_wdata    in   DATA_WIDTH  rs2 value; low 2^size bytes are stored.
// - r_valid_o    out  1           Read request to arbiter.
// - r_addr_o     out  ADDR_WIDTH  EA (unaligned byte address, not rounded).
// - r_size_o     out  3           AXI size = funct3[1:0].
// - r_ready_i    in   1           Read data beat valid.
// - r_last_i     in   1           Last beat; completion = r_ready_i & r_last_i.
// - r_data_i     in   DATA_WIDTH  Full bus word, lane-positioned.
// - w_valid_o    out  1           Write request to arbiter.
// - w_addr_o     out  ADDR_WIDTH  EA.
// - w_size_o     out  3           AXI size = funct3[1:0].
// - w_data_o     out  DATA_WIDTH  req_wdata << (8*EA[OFS_W-1:0]).
// - w_strb_o     out  DATA_WIDTH/8 ((1<<(1<<size))-1) << EA[OFS_W-1:0].
// - w_last_i     in   1           Write completion.
// - resp_valid   out  1           Result/ack available to WB.
// - resp_ack     in   1           WB consumes response (ex_to_wb).
// - resp_data    out  DATA_WIDTH  Extended load result; 0 for stores and errors.
// - resp_err     out  1           Timeout (or misalign with LSU_MISALIGN_TRAP_EN).
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1; r/w_valid_o=0; resp_valid=0; resp_err=0; resp_data=0; counter=0.
// - Accept edge latches store, funct3, EA, wdata; next state RD (load) or WR (store).
// - RD/WR: matching *_valid_o held high, addr/size/data/strb stable until completion.
// - RD completion edge: resp_data <= ext((r_data_i >> 8*EA[OFS_W-1:0]), size, funct3[2]) -> DONE.
// - WR completion edge (w_last_i): resp_data <= 0 -> DONE. Min latency accept->resp_valid = 2 cycles.
// - Watchdog: counter clears on accept, increments each RD/WR cycle; at TIMEOUT_CYCLES-1 without
//   completion -> DONE with resp_err=1, resp_data=0, valid dropped. Completion same cycle wins (no err).
// - DONE: resp_valid=1 and stable until resp_ack; ack edge -> IDLE, resp_valid=0, resp_err=0.
// - req_valid outside IDLE ignored; completions in IDLE/DONE ignored (no state change).
// - Reset mid-op: synchronous return to IDLE; valids low from the next cycle; pending beat is dropped.
// - Unsigned word load (LWU) extends with zeros on 64-bit; size 3 on 32-bit -> treated as W.
// CONFIGURATION
// - LSU_MISALIGN_TRAP_EN defined: EA not aligned to size -> no bus request; accept -> DONE next cycle,
//   resp_err=1, resp_data=0.
// - Undefined: misaligned EA issued unchanged; strobe/shift bits beyond lane are truncated.
// TESTING
// - LB at base=0x8000_0000, imm=3, r_data_i=0x80FF_FF12 -> r_addr_o=0x8000_0003, resp_data=0xFFFF_FF80.
// - LHU at EA 0x...2, r_data_i=0xBEEF_0000 -> resp_data=0x0000_BEEF, resp_err=0.
// - SB wdata=0xAB at EA 0x...1 -> w_data_o=0x0000_AB00, w_strb_o=4'b0010; resp_valid 1 cycle after w_last_i.
// - TIMEOUT_CYCLES=4, no r_ready_i -> resp_valid, resp_err=1 after 4 RD cycles; r_valid_o drops.
// - resp_ack held low 5 cycles -> resp_valid/resp_data stable; req_ready=0 throughout.
// - Reset asserted in RD -> next cycle r_valid_o=0, req_ready=1; LW at EA 0x...2 with macro -> resp_err=1, no r_valid_o.

Source files
------------

// File: rtl/ysyx_23060077_lsu_align.sv
// Load/store unit between EX and the memory arbiter: lane alignment, load extension, bus watchdog.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned EAs answer with an error instead of a bus request.
module ysyx_23060077_lsu_align #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    // Handshakes: a transfer happens on an edge where valid and ready (or ack / last) are both high;
    // a raised valid and its payload stay stable until that edge.
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [2:0]              req_funct3,
    input  logic [DATA_WIDTH-1:0]   req_base,
    input  logic [DATA_WIDTH-1:0]   req_imm,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    r_valid_o,
    output logic [ADDR_WIDTH-1:0]   r_addr_o,
    output logic [2:0]              r_size_o,
    input  logic                    r_ready_i,
    input  logic                    r_last_i,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    output logic                    w_valid_o,
    output logic [ADDR_WIDTH-1:0]   w_addr_o,
    output logic [2:0]              w_size_o,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    input  logic                    w_last_i,
    output logic                    resp_valid,
    input  logic                    resp_ack,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_err,
    output logic [1:0]              state_dbg
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int LM_W  = 2 * NB;
    localparam logic [1:0] MAX_SIZE = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_n;

    logic                  store_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] ea_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  resp_err_q;

    logic [DATA_WIDTH-1:0] ea;
    logic [1:0]            req_size;
    logic                  accept;
    logic                  busy;
    logic                  rd_done;
    logic                  wr_done;
    logic                  timeout_hit;
    logic                  trap;

    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [LM_W-1:0]       lane_mask;
    logic [LM_W-1:0]       strb_full;

    assign ea       = req_base + req_imm;
    // Doubleword size on a 32-bit bus behaves as a word access.
    assign req_size = (req_funct3[1:0] > MAX_SIZE) ? MAX_SIZE : req_funct3[1:0];
    assign accept   = req_valid && req_ready;
    assign busy     = (state == S_RD) || (state == S_WR);
    assign rd_done  = (state == S_RD) && r_ready_i && r_last_i;
    assign wr_done  = (state == S_WR) && w_last_i;
    assign timeout_hit = WD_EN && busy && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic [OFS_W-1:0] align_mask;
    assign align_mask = OFS_W'((1 << req_size) - 1);
    assign trap       = |(ea[OFS_W-1:0] & align_mask);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Completion beats the watchdog when both land on the same edge.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (trap) begin
                        state_n = S_DONE;
                    end else if (req_store) begin
                        state_n = S_WR;
                    end else begin
                        state_n = S_RD;
                    end
                end
            end
            S_RD: begin
                if (rd_done || timeout_hit) begin
                    state_n = S_DONE;
                end
            end
            S_WR: begin
                if (wr_done || timeout_hit) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ack) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            store_q     <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            ea_q        <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                store_q <= req_store;
                size_q  <= req_size;
                uns_q   <= req_funct3[2];
                ea_q    <= ea;
                wdata_q <= req_wdata;
                cnt     <= '0;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept && trap) begin
                resp_data_q <= '0;
                resp_err_q  <= 1'b1;
            end else if (rd_done) begin
                resp_data_q <= load_ext;
                resp_err_q  <= 1'b0;
            end else if (wr_done) begin
                resp_data_q <= '0;
                resp_err_q  <= 1'b0;
            end else if (timeout_hit) begin
                resp_data_q <= '0;
                resp_err_q  <= 1'b1;
            end else if ((state == S_DONE) && resp_ack) begin
                resp_data_q <= '0;
                resp_err_q  <= 1'b0;
            end
        end
    end

    // Sign bit is the top set bit of the keep mask; full-width loads need no extension.
    always_comb begin
        lane_data = r_data_i >> {ea_q[OFS_W-1:0], 3'b000};
        if (size_q >= MAX_SIZE) begin
            keep = '1;
        end else begin
            keep = (DATA_WIDTH'(1) << (8 << size_q)) - DATA_WIDTH'(1);
        end
        sign_bit = |(lane_data & keep & ~(keep >> 1));
        load_ext = lane_data & keep;
        if (!uns_q && sign_bit && (size_q < MAX_SIZE)) begin
            load_ext = load_ext | ~keep;
        end
    end

    always_comb begin
        lane_mask = (LM_W'(1) << (1 << size_q)) - LM_W'(1);
        strb_full = lane_mask << ea_q[OFS_W-1:0];
    end

    assign req_ready  = (state == S_IDLE);
    assign r_valid_o  = (state == S_RD);
    assign w_valid_o  = (state == S_WR);
    assign r_addr_o   = ADDR_WIDTH'(ea_q);
    assign w_addr_o   = ADDR_WIDTH'(ea_q);
    assign r_size_o   = {1'b0, size_q};
    assign w_size_o   = {1'b0, size_q};
    assign w_data_o   = wdata_q << {ea_q[OFS_W-1:0], 3'b000};
    assign w_strb_o   = (state == S_WR) ? strb_full[NB-1:0] : '0;
    assign resp_valid = (state == S_DONE);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign state_dbg  = state;

endmodule
